// File: rtl/video_pkg.sv
// video_pkg: shared pattern codes, counter width and default 640x480 raster timing
package video_pkg;
  typedef enum logic [1:0] {
    PAT_HRAMP  = 2'd0,
    PAT_VRAMP  = 2'd1,
    PAT_CHECK  = 2'd2,
    PAT_SCROLL = 2'd3
  } pat_e;
  localparam int CNT_W       = 12;
  localparam int DEF_H_DISP  = 640;
  localparam int DEF_V_DISP  = 480;
  localparam int DEF_H_SYNC  = 96;
  localparam int DEF_H_BACK  = 48;
  localparam int DEF_H_FRONT = 16;
  localparam int DEF_V_SYNC  = 2;
  localparam int DEF_V_BACK  = 33;
  localparam int DEF_V_FRONT = 10;
endpackage

// File: rtl/video_timing_cnt.sv
// video_timing_cnt: h/v raster counters and region decode; clk/rst_n in; run, hs_n, vs_n, de, frame_start, frame_end, x, y out
module video_timing_cnt
  import video_pkg::*;
#(
  parameter int H_DISP  = DEF_H_DISP,
  parameter int V_DISP  = DEF_V_DISP,
  parameter int H_SYNC  = DEF_H_SYNC,
  parameter int H_BACK  = DEF_H_BACK,
  parameter int H_FRONT = DEF_H_FRONT,
  parameter int V_SYNC  = DEF_V_SYNC,
  parameter int V_BACK  = DEF_V_BACK,
  parameter int V_FRONT = DEF_V_FRONT
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic       run,
  output logic       hs_n,
  output logic       vs_n,
  output logic       de,
  output logic       frame_start,
  output logic       frame_end,
  output logic [7:0] x,
  output logic [7:0] y
);
  localparam int H_TOTAL = H_SYNC + H_BACK + H_DISP + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_DISP + V_FRONT;
  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_SY   = CNT_W'(H_SYNC);
  localparam logic [CNT_W-1:0] V_SY   = CNT_W'(V_SYNC);
  localparam logic [CNT_W-1:0] H_A0   = CNT_W'(H_SYNC + H_BACK);
  localparam logic [CNT_W-1:0] V_A0   = CNT_W'(V_SYNC + V_BACK);
  localparam logic [CNT_W-1:0] H_A1   = CNT_W'(H_SYNC + H_BACK + H_DISP);
  localparam logic [CNT_W-1:0] V_A1   = CNT_W'(V_SYNC + V_BACK + V_DISP);
  logic [CNT_W-1:0] h_cnt, v_cnt;
  logic h_wrap, v_wrap;
  assign h_wrap = h_cnt == H_LAST;
  assign v_wrap = v_cnt == V_LAST;
  // run holds the counters at (0,0) for one extra cycle after reset release
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      run   <= 1'b0;
      h_cnt <= '0;
      v_cnt <= '0;
    end else begin
      run <= 1'b1;
      if (run) begin
        h_cnt <= h_wrap ? '0 : h_cnt + CNT_W'(1);
        if (h_wrap) v_cnt <= v_wrap ? '0 : v_cnt + CNT_W'(1);
      end
    end
  assign hs_n        = h_cnt >= H_SY;
  assign vs_n        = v_cnt >= V_SY;
  assign de          = h_cnt >= H_A0 && h_cnt < H_A1 && v_cnt >= V_A0 && v_cnt < V_A1;
  assign frame_start = h_cnt == '0 && v_cnt == '0;
  assign frame_end   = run && h_wrap && v_wrap;
  assign x           = h_cnt[7:0] - H_A0[7:0];
  assign y           = v_cnt[7:0] - V_A0[7:0];
endmodule

// File: rtl/gray_pattern_gen.sv
// gray_pattern_gen: raster timing + 8-bit gray test pattern; clk/rst_n/pattern_sel in; gray_hsync/vsync/data/de and frame_cnt out
module gray_pattern_gen
  import video_pkg::*;
#(
  parameter int H_DISP  = DEF_H_DISP,
  parameter int V_DISP  = DEF_V_DISP,
  parameter int H_SYNC  = DEF_H_SYNC,
  parameter int H_BACK  = DEF_H_BACK,
  parameter int H_FRONT = DEF_H_FRONT,
  parameter int V_SYNC  = DEF_V_SYNC,
  parameter int V_BACK  = DEF_V_BACK,
  parameter int V_FRONT = DEF_V_FRONT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] pattern_sel,
  output logic       gray_hsync,
  output logic       gray_vsync,
  output logic [7:0] gray_data,
  output logic       gray_de,
  output logic [7:0] frame_cnt
);
  logic run, hs_n, vs_n, de, frame_start, frame_end;
  logic [7:0] x, y, pix;
  pat_e pat_q;
  video_timing_cnt #(
    .H_DISP(H_DISP), .V_DISP(V_DISP), .H_SYNC(H_SYNC), .H_BACK(H_BACK),
    .H_FRONT(H_FRONT), .V_SYNC(V_SYNC), .V_BACK(V_BACK), .V_FRONT(V_FRONT)
  ) u_tim (
    .clk(clk), .rst_n(rst_n), .run(run), .hs_n(hs_n), .vs_n(vs_n), .de(de),
    .frame_start(frame_start), .frame_end(frame_end), .x(x), .y(y)
  );
  always_comb
    pix = pat_q == PAT_HRAMP ? x :
          pat_q == PAT_VRAMP ? y :
          pat_q == PAT_CHECK ? {8{x[5] ^ y[5]}} : x + frame_cnt;
  // pat_q only reloads at (0,0) so a frame never mixes two patterns
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pat_q      <= PAT_HRAMP;
      frame_cnt  <= '0;
      gray_hsync <= 1'b1;
      gray_vsync <= 1'b1;
      gray_de    <= 1'b0;
      gray_data  <= '0;
    end else begin
      if (frame_start) pat_q <= pat_e'(pattern_sel);
      if (frame_end) frame_cnt <= frame_cnt + 8'd1;
      if (run) begin
        gray_hsync <= hs_n;
        gray_vsync <= vs_n;
        gray_de    <= de;
        gray_data  <= de ? pix : '0;
      end
    end
endmodule

// File: tb/tb_gray_pattern_gen.sv
// tb_gray_pattern_gen: randomized pattern_sel traffic against a position-based raster model
module tb_gray_pattern_gen;
  localparam int HT = 14, VT = 7, F = HT * VT;
  localparam int BHT = 800;
  typedef struct packed {
    logic hs, vs, de;
    logic [7:0] d, fc;
  } exp_t;
  logic clk = 1'b0, rst_n, rstb_n, mon_en = 1'b0, big_done = 1'b0;
  logic [1:0] pattern_sel, msel = 2'd0, sel_big = 2'd2;
  logic gray_hsync, gray_vsync, gray_de, gb_hsync, gb_vsync, gb_de;
  logic [7:0] gray_data, frame_cnt, gb_data, gb_fc;
  int k = 0, kb = 0, checks = 0, errors = 0;
  always #5 clk = ~clk;
  gray_pattern_gen #(
    .H_DISP(8), .V_DISP(4), .H_SYNC(2), .H_BACK(2), .H_FRONT(2),
    .V_SYNC(1), .V_BACK(1), .V_FRONT(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pattern_sel(pattern_sel), .gray_hsync(gray_hsync),
    .gray_vsync(gray_vsync), .gray_data(gray_data), .gray_de(gray_de), .frame_cnt(frame_cnt)
  );
  gray_pattern_gen dut_big (
    .clk(clk), .rst_n(rstb_n), .pattern_sel(sel_big), .gray_hsync(gb_hsync),
    .gray_vsync(gb_vsync), .gray_data(gb_data), .gray_de(gb_de), .frame_cnt(gb_fc)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask
  // edges since reset release; outputs after edge kk describe raster position kk-2
  function automatic exp_t model(input int kk, input logic [1:0] s);
    exp_t e;
    int pos, h, v, f, xx, yy;
    e = '{hs: 1'b1, vs: 1'b1, de: 1'b0, d: 8'd0, fc: 8'd0};
    if (kk >= 1) e.fc = 8'(((kk - 1) / F) % 256);
    if (kk < 2) return e;
    pos = kk - 2;
    h = pos % HT;
    v = (pos / HT) % VT;
    f = pos / F;
    xx = h - 4;
    yy = v - 2;
    e.hs = h >= 2;
    e.vs = v >= 1;
    e.de = xx >= 0 && xx < 8 && yy >= 0 && yy < 4;
    if (e.de)
      case (s)
        2'd0: e.d = 8'(xx);
        2'd1: e.d = 8'(yy);
        2'd2: e.d = (((xx / 32) % 2) != ((yy / 32) % 2)) ? 8'd255 : 8'd0;
        default: e.d = 8'((xx + f) % 256);
      endcase
    return e;
  endfunction
  always @(posedge clk or negedge rst_n)
    if (!rst_n) k = 0;
    else begin
      k = k + 1;
      if (k >= 2 && (k - 2) % F == 0) msel = pattern_sel;
    end
  always @(posedge clk or negedge rstb_n)
    if (!rstb_n) kb = 0;
    else kb = kb + 1;
  always @(negedge clk)
    if (mon_en) begin
      exp_t e;
      e = model(k, msel);
      chk("hsync", gray_hsync, e.hs);
      chk("vsync", gray_vsync, e.vs);
      chk("de", gray_de, e.de);
      chk("data", gray_data, e.d);
      chk("frame_cnt", frame_cnt, e.fc);
    end
  task automatic wait_abs(input int p);
    int n = 0;
    while (!(k >= 2 && k - 2 == p) && n < 40000) begin
      @(negedge clk);
      n++;
    end
    chk("wait_pos", n < 40000, 1);
  endtask
  task automatic wait_big(input int p);
    int n = 0;
    while (!(kb >= 2 && kb - 2 == p) && n < 60000) begin
      @(negedge clk);
      n++;
    end
    chk("wait_big", n < 60000, 1);
  endtask
  initial begin
    rstb_n = 1'b0;
    repeat (2) @(negedge clk);
    #2 rstb_n = 1'b1;
    wait_big(35 * BHT + 144 + 31);
    chk("chk_x31_y0", gb_data, 0);
    chk("chk_de", gb_de, 1);
    wait_big(35 * BHT + 144 + 32);
    chk("chk_x32_y0", gb_data, 255);
    wait_big(67 * BHT + 144);
    chk("chk_x0_y32", gb_data, 255);
    big_done = 1'b1;
  end
  initial begin
    int hs_lo = 0, de_n = 0, vs_lo = 0, n;
    int vs_fall[$];
    logic prev_vs = 1'b1;
    rst_n = 1'b0;
    pattern_sel = 2'd0;
    repeat (3) @(negedge clk);
    mon_en = 1'b1;
    chk("rst_hsync", gray_hsync, 1);
    chk("rst_vsync", gray_vsync, 1);
    chk("rst_de", gray_de, 0);
    chk("rst_data", gray_data, 0);
    chk("rst_fc", frame_cnt, 0);
    #2 rst_n = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 2 * F; i++) begin
      hs_lo += int'(!gray_hsync);
      de_n  += int'(gray_de);
      vs_lo += int'(!gray_vsync);
      if (prev_vs && !gray_vsync) vs_fall.push_back(k);
      prev_vs = gray_vsync;
      @(negedge clk);
    end
    chk("hsync_low_cycles", hs_lo, 2 * 2 * VT);
    chk("de_cycles", de_n, 2 * 32);
    chk("vsync_low_cycles", vs_lo, 2 * 14);
    chk("vsync_falls", vs_fall.size(), 2);
    chk("vsync_period", vs_fall.size() >= 2 ? vs_fall[1] - vs_fall[0] : 0, F);
    for (int x = 0; x < 8; x++) begin
      wait_abs(2 * F + 32 + x);
      chk("hramp", gray_data, x);
    end
    pattern_sel = 2'd1;
    for (int y = 0; y < 4; y++) begin
      wait_abs(3 * F + (2 + y) * HT + 9);
      chk("vramp", gray_data, y);
    end
    pattern_sel = 2'd0;
    wait_abs(4 * F + 50);
    pattern_sel = 2'd1;
    wait_abs(4 * F + 4 * HT + 7);
    chk("toggle_hold", gray_data, 3);
    wait_abs(5 * F + 2 * HT + 5);
    chk("toggle_next_y0", gray_data, 0);
    wait_abs(5 * F + 3 * HT + 10);
    chk("toggle_next_y1", gray_data, 1);
    repeat (40) begin
      repeat ($urandom_range(5, 60)) @(negedge clk);
      pattern_sel = 2'($urandom_range(0, 3));
    end
    pattern_sel = 2'd3;
    wait_abs(255 * F + 32);
    chk("scroll_f255", gray_data, 255);
    chk("fc_255", frame_cnt, 255);
    wait_abs(256 * F + 32);
    chk("scroll_f256", gray_data, 0);
    chk("fc_wrap", frame_cnt, 0);
    wait_abs(257 * F + 36);
    #2 rst_n = 1'b0;
    #1;
    chk("async_hsync", gray_hsync, 1);
    chk("async_vsync", gray_vsync, 1);
    chk("async_de", gray_de, 0);
    chk("async_data", gray_data, 0);
    chk("async_fc", frame_cnt, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    n = 0;
    while (n < 10) begin
      @(posedge clk);
      n++;
      #1;
      if (!gray_hsync) break;
    end
    chk("release_hsync_latency", n, 2);
    chk("release_fc", frame_cnt, 0);
    repeat (2 * F) @(negedge clk);
    n = 0;
    while (!big_done && n < 60000) begin
      @(negedge clk);
      n++;
    end
    chk("big_done", big_done, 1);
    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
